// File: rtl/tx_ctrl_pkg.sv
// Shared definitions for the serial transmit controller path.
// Holds the controller state encoding and the default frame parameters
// used by tx_arbiter, baud_gen and the receiver side.
package tx_ctrl_pkg;

  localparam int unsigned DEF_WIDTH    = 8;   // data bits per frame
  localparam int unsigned FRAME_BITS   = 10;  // start + 8 data + stop
  localparam int unsigned DEF_BAUD_DIV = 16;  // clk cycles per baud tick

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

endpackage : tx_ctrl_pkg

// File: rtl/baud_gen.sv
// Free-running baud enable generator.
// Counts 0..BAUD_DIV-1 continuously and emits a one-clk baud_en pulse
// while the count sits at BAUD_DIV-1, giving a pulse every BAUD_DIV clks.
// Ports:
//   clk     - system clock
//   rst_n   - async active-low reset (count returns to 0, baud_en low)
//   baud_en - registered one-clk enable pulse
module baud_gen
  import tx_ctrl_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic baud_en
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             en_d;

  // Next count; the pulse is set one clk early so the registered output
  // lines up with the cycle in which the count equals BAUD_DIV-1.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_W'(BAUD_DIV - 1)) begin
      cnt_d = '0;
    end
    en_d = (cnt_q == CNT_W'(BAUD_DIV - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      baud_en <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      baud_en <= en_d;
    end
  end

endmodule : baud_gen

// File: rtl/tx_arbiter.sv
// Round-robin controller sharing one serial transmitter among N requesters.
// Generates the transmitter baud enable, picks a winner, presents its byte
// with a held tx_start, follows tx_busy through the frame and returns a
// one-clk ack (plus err on a start timeout) to the granted requester.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   req         - per-requester request, held until ack
//   req_data    - requester i byte at [i*WIDTH +: WIDTH]
//   ack         - one-clk completion pulse, one-hot
//   err         - one-clk pulse with ack when tx_busy never rose
//   active_id   - current / last granted requester
//   tx_en       - baud enable to the transmitter
//   tx_start    - start request to the transmitter
//   tx_pi       - byte to the transmitter
//   tx_busy     - transmitter busy flag
module tx_arbiter
  import tx_ctrl_pkg::*;
#(
  parameter int unsigned N             = 4,
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned BAUD_DIV      = DEF_BAUD_DIV,
  parameter int unsigned START_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     req_data,
  output logic [N-1:0]           ack,
  output logic                   err,
  output logic [$clog2(N)-1:0]   active_id,
  output logic                   tx_en,
  output logic                   tx_start,
  output logic [WIDTH-1:0]       tx_pi,
  input  logic                   tx_busy
);

  localparam int unsigned ID_W  = $clog2(N);
  localparam int unsigned TMO_W = $clog2(START_TIMEOUT + 1);

  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  last_d;
  logic [TMO_W-1:0] tmo_q;
  logic [TMO_W-1:0] tmo_d;

  logic [ID_W-1:0]  id_d;
  logic [WIDTH-1:0] pi_d;
  logic             start_d;
  logic [N-1:0]     ack_d;
  logic             err_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] win_data;

  // Baud enable runs in every state, independent of the arbiter.
  baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .baud_en (tx_en)
  );

  // Round-robin search: first set req starting just after the last winner.
  always_comb begin : rr_select
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = ID_W'((32'(last_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Winner's byte slice.
  always_comb begin : data_mux
    win_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (win_id == ID_W'(i)) begin
        win_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin : fsm_next
    state_d = state_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    id_d    = active_id;
    pi_d    = tx_pi;
    start_d = tx_start;
    ack_d   = '0;
    err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A transmitter still busy (e.g. mid-frame across our reset) blocks grants.
        if (win_found && !tx_busy) begin
          state_d = ST_START;
          id_d    = win_id;
          pi_d    = win_data;
          tmo_d   = '0;
          start_d = 1'b1;
        end
      end

      ST_START: begin
        if (tx_busy) begin
          state_d = ST_WAIT;
          start_d = 1'b0;
        end else if (tx_en) begin
          if (32'(tmo_q) + 32'd1 >= START_TIMEOUT) begin
            // Transmitter never accepted the byte: finish with an error.
            state_d = ST_DONE;
            start_d = 1'b0;
            ack_d   = N'(1) << active_id;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end

      ST_WAIT: begin
        if (!tx_busy) begin
          state_d = ST_DONE;
          ack_d   = N'(1) << active_id;
        end
      end

      ST_DONE: begin
        last_d  = active_id;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= ID_W'(N - 1);
      tmo_q     <= '0;
      active_id <= '0;
      tx_pi     <= '0;
      tx_start  <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      active_id <= id_d;
      tx_pi     <= pi_d;
      tx_start  <= start_d;
      ack       <= ack_d;
      err       <= err_d;
    end
  end

endmodule : tx_arbiter

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: behavioural transmitter, request producers and a
// grant/ack scoreboard; expected entries are queued when requests are raised.
module tb_tx_arbiter;
  import tx_ctrl_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned BD = 4;

  typedef struct { logic [1:0] id; logic [7:0] data; int cyc; } grant_t;
  typedef struct { logic [3:0] bits; logic err; int en_cnt; int cyc; } ack_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     ack;
  logic             err;
  logic [1:0]       active_id;
  logic             tx_en;
  logic             tx_start;
  logic [W-1:0]     tx_pi;
  logic             tx_busy;

  logic [N-1:0]     ack2, ack16;
  logic             err2, err16, en2, en16, st2, st16;
  logic [1:0]       id2, id16;
  logic [W-1:0]     pi2, pi16;
  logic [N-1:0]     no_req = '0;
  logic [N*W-1:0]   no_data = '0;
  logic             idle_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  tx_arbiter #(.N(N), .WIDTH(W), .BAUD_DIV(BD), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack), .err(err),
    .active_id(active_id), .tx_en(tx_en), .tx_start(tx_start), .tx_pi(tx_pi), .tx_busy(tx_busy));

  tx_arbiter #(.N(N), .WIDTH(W), .BAUD_DIV(2), .START_TIMEOUT(4)) u_div2 (
    .clk(clk), .rst_n(rst_n), .req(no_req), .req_data(no_data), .ack(ack2), .err(err2),
    .active_id(id2), .tx_en(en2), .tx_start(st2), .tx_pi(pi2), .tx_busy(idle_busy));

  tx_arbiter #(.N(N), .WIDTH(W), .BAUD_DIV(16), .START_TIMEOUT(4)) u_div16 (
    .clk(clk), .rst_n(rst_n), .req(no_req), .req_data(no_data), .ack(ack16), .err(err16),
    .active_id(id16), .tx_en(en16), .tx_start(st16), .tx_pi(pi16), .tx_busy(idle_busy));

  // Behavioural transmitter: start bit, 8 bits MSB first, stop bit, one per tx_en.
  logic       stub_busy = 1'b0;
  logic       x_busy = 1'b0;
  logic       x_so = 1'b1;
  logic [7:0] x_sh = '0;
  int         x_cnt = 0;
  logic       so_q[$];

  assign tx_busy = stub_busy ? 1'b0 : x_busy;

  always @(posedge clk) begin
    if (tx_en) begin
      if (!x_busy) begin
        if (tx_start && !stub_busy) begin
          x_busy <= 1'b1;
          x_so   <= 1'b0;
          x_sh   <= tx_pi;
          x_cnt  <= 0;
          so_q.push_back(1'b0);
        end
      end else if (x_cnt < 8) begin
        x_so  <= x_sh[7];
        so_q.push_back(x_sh[7]);
        x_sh  <= {x_sh[6:0], 1'b0};
        x_cnt <= x_cnt + 1;
      end else if (x_cnt == 8) begin
        x_so  <= 1'b1;
        so_q.push_back(1'b1);
        x_cnt <= 9;
      end else begin
        x_busy <= 1'b0;
      end
    end
  end

  // Producers: req stays high until an ack arrives, unless held continuously.
  logic [N-1:0] req_on = '0;
  logic [N-1:0] hold = '0;
  int           ack_cnt [N];
  int           ack_base[N];

  always_comb begin
    for (int i = 0; i < N; i++) req[i] = req_on[i] && (hold[i] || ack_cnt[i] == ack_base[i]);
  end

  // Monitor: log grants (tx_start rise) and ack pulses.
  grant_t grant_q[$], exp_grant_q[$];
  ack_t   ack_q[$], exp_ack_q[$];
  int     cyc = 0;
  int     en_start_cnt = 0;
  logic   prev_start = 1'b0;

  initial for (int i = 0; i < N; i++) begin ack_cnt[i] = 0; ack_base[i] = 0; end

  always @(negedge clk) begin
    cyc++;
    if (tx_start && !prev_start) begin
      grant_q.push_back('{id: active_id, data: tx_pi, cyc: cyc});
      en_start_cnt = 0;
    end
    if (tx_start && tx_en) en_start_cnt++;
    if (ack != '0) begin
      ack_q.push_back('{bits: ack, err: err, en_cnt: en_start_cnt, cyc: cyc});
      for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    end
    prev_start = tx_start;
  end

  function automatic logic [9:0] pack_so();
    logic [9:0] v = 'x;
    for (int k = 0; k < FRAME_BITS; k++) if (k < so_q.size()) v[9-k] = so_q[k];
    return v;
  endfunction

  task automatic raise(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) ack_base[i] = ack_cnt[i];
    req_on = m;
  endtask

  task automatic wait_acks(input int n, input int limit);
    for (int c = 0; c < limit && ack_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic settle();
    int quiet = 0;
    req_on = '0;
    hold   = '0;
    for (int c = 0; c < 600 && quiet < 4; c++) begin
      @(negedge clk);
      if (!tx_start && !tx_busy && ack == '0) quiet++; else quiet = 0;
    end
    grant_q.delete(); ack_q.delete(); exp_grant_q.delete(); exp_ack_q.delete(); so_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", tx_start); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", tx_en); end
    checks++; if (tx_pi !== 8'h00) begin errors++; $display("FAIL reset_pi: got %h want 00", tx_pi); end
    checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", active_id); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    grant_t g; ack_t a; ack_t ea;
    settle();
    req_data[7:0] = 8'hA5;
    exp_ack_q.push_back('{bits: 4'b0001, err: 1'b0, en_cnt: 0, cyc: 0});
    raise(4'b0001);
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_pi !== 8'hA5 || active_id !== 2'd0) begin
      errors++; $display("FAIL single_latency: got start=%b pi=%h id=%0d want 1 a5 0", tx_start, tx_pi, active_id);
    end
    wait_acks(1, 200);
    checks++;
    if (ack_q.size() == 0 || grant_q.size() == 0) begin
      errors++; $display("FAIL single_ack: got %0d acks want 1", ack_q.size());
    end else begin
      g = grant_q.pop_front(); a = ack_q.pop_front(); ea = exp_ack_q.pop_front();
      if (a.bits !== ea.bits || a.err !== ea.err) begin
        errors++; $display("FAIL single_ack: got ack=%b err=%b want %b %b", a.bits, a.err, ea.bits, ea.err);
      end
    end
    checks++;
    if (pack_so() !== 10'b0101001011) begin
      errors++; $display("FAIL single_frame: got %b want 0101001011", pack_so());
    end
  endtask

  task automatic test_all();
    grant_t g; grant_t eg; ack_t a; ack_t ea;
    int prev_ack_cyc = 0;
    settle();
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
      exp_grant_q.push_back('{id: 2'(i), data: 8'(8'h11 * (i + 1)), cyc: 0});
      exp_ack_q.push_back('{bits: 4'(1 << i), err: 1'b0, en_cnt: 0, cyc: 0});
    end
    raise(4'b1111);
    wait_acks(4, 1000);
    for (int i = 0; i < 4; i++) begin
      if (grant_q.size() == 0 || ack_q.size() == 0) begin
        checks++; errors++; $display("FAIL all_count: got %0d acks want 4", i); break;
      end
      g = grant_q.pop_front(); eg = exp_grant_q.pop_front();
      a = ack_q.pop_front();   ea = exp_ack_q.pop_front();
      checks++;
      if (g.id !== eg.id || g.data !== eg.data) begin
        errors++; $display("FAIL all_grant%0d: got id=%0d pi=%h want %0d %h", i, g.id, g.data, eg.id, eg.data);
      end
      checks++;
      if (a.bits !== ea.bits || a.err !== ea.err) begin
        errors++; $display("FAIL all_ack%0d: got %b/%b want %b/%b", i, a.bits, a.err, ea.bits, ea.err);
      end
      if (i > 0) begin
        checks++;
        if (g.cyc - prev_ack_cyc != 2) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d clks want 2", i, g.cyc - prev_ack_cyc);
        end
      end
      prev_ack_cyc = a.cyc;
    end
  endtask

  task automatic test_fairness();
    grant_t g; grant_t eg;
    settle();
    do_reset();
    req_data = {8'h00, 8'hC3, 8'h00, 8'h5A};
    for (int i = 0; i < 4; i++)
      exp_grant_q.push_back('{id: (i % 2 == 0) ? 2'd0 : 2'd2, data: (i % 2 == 0) ? 8'h5A : 8'hC3, cyc: 0});
    hold = 4'b0101;
    raise(4'b0101);
    wait_acks(4, 1000);
    hold = '0;
    req_on = '0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_q.size() == 0) begin
        errors++; $display("FAIL fair_count: got %0d grants want 4", i); break;
      end
      g = grant_q.pop_front(); eg = exp_grant_q.pop_front();
      if (g.id !== eg.id || g.data !== eg.data) begin
        errors++; $display("FAIL fair_grant%0d: got id=%0d pi=%h want %0d %h", i, g.id, g.data, eg.id, eg.data);
      end
    end
  endtask

  task automatic test_timeout();
    ack_t a; ack_t ea;
    settle();
    stub_busy = 1'b1;
    req_data[15:8] = 8'h77;
    exp_ack_q.push_back('{bits: 4'b0010, err: 1'b1, en_cnt: 4, cyc: 0});
    raise(4'b0010);
    wait_acks(1, 300);
    checks++;
    if (ack_q.size() == 0) begin
      errors++; $display("FAIL timeout_ack: got none want 0010/1");
    end else begin
      a = ack_q.pop_front(); ea = exp_ack_q.pop_front();
      if (a.bits !== ea.bits || a.err !== ea.err || a.en_cnt != ea.en_cnt) begin
        errors++; $display("FAIL timeout_ack: got %b/%b after %0d tx_en want %b/%b after %0d",
                           a.bits, a.err, a.en_cnt, ea.bits, ea.err, ea.en_cnt);
      end
    end
    stub_busy = 1'b0;
    settle();
    req_data[31:24] = 8'h3C;
    exp_ack_q.push_back('{bits: 4'b1000, err: 1'b0, en_cnt: 0, cyc: 0});
    raise(4'b1000);
    wait_acks(1, 300);
    checks++;
    if (ack_q.size() == 0) begin
      errors++; $display("FAIL timeout_next: got no ack want 1000/0");
    end else begin
      a = ack_q.pop_front(); ea = exp_ack_q.pop_front();
      if (a.bits !== ea.bits || a.err !== ea.err) begin
        errors++; $display("FAIL timeout_next: got %b/%b want %b/%b", a.bits, a.err, ea.bits, ea.err);
      end
    end
    checks++;
    if (pack_so() !== {1'b0, 8'h3C, 1'b1}) begin
      errors++; $display("FAIL timeout_frame: got %b want %b", pack_so(), {1'b0, 8'h3C, 1'b1});
    end
  endtask

  task automatic test_reset_midframe();
    grant_t g; ack_t a; ack_t ea;
    int viol = 0;
    int c;
    settle();
    req_data[23:16] = 8'h96;
    raise(4'b0100);
    for (c = 0; c < 400 && so_q.size() < 6; c++) @(negedge clk);
    checks++;
    if (so_q.size() < 6) begin errors++; $display("FAIL midframe_reach: got %0d bits want 6", so_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0 || err !== 1'b0 || tx_start !== 1'b0 || tx_en !== 1'b0 || tx_pi !== 8'h00 || active_id !== 2'd0) begin
      errors++; $display("FAIL async_reset: got ack=%b err=%b st=%b en=%b pi=%h id=%0d want all 0",
                         ack, err, tx_start, tx_en, tx_pi, active_id);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (c = 0; c < 400 && tx_busy; c++) begin
      @(negedge clk);
      if (tx_busy && tx_start) viol++;
    end
    checks++;
    if (viol != 0 || tx_busy) begin
      errors++; $display("FAIL busy_block: got %0d grant cycles busy=%b want 0 0", viol, tx_busy);
    end
    checks++;
    if (ack_q.size() != 0) begin errors++; $display("FAIL abort_ack: got %0d acks want 0", ack_q.size()); end
    so_q.delete(); grant_q.delete(); ack_q.delete();
    exp_ack_q.push_back('{bits: 4'b0100, err: 1'b0, en_cnt: 0, cyc: 0});
    wait_acks(1, 300);
    checks++;
    if (ack_q.size() == 0 || grant_q.size() == 0) begin
      errors++; $display("FAIL resend_ack: got %0d acks want 1", ack_q.size());
    end else begin
      g = grant_q.pop_front(); a = ack_q.pop_front(); ea = exp_ack_q.pop_front();
      if (g.id !== 2'd2 || g.data !== 8'h96 || a.bits !== ea.bits || a.err !== ea.err) begin
        errors++; $display("FAIL resend_ack: got id=%0d pi=%h ack=%b/%b want 2 96 %b/%b",
                           g.id, g.data, a.bits, a.err, ea.bits, ea.err);
      end
    end
    checks++;
    if (pack_so() !== {1'b0, 8'h96, 1'b1}) begin
      errors++; $display("FAIL resend_frame: got %b want %b", pack_so(), {1'b0, 8'h96, 1'b1});
    end
  endtask

  task automatic test_divider();
    int bad2 = 0, bad4 = 0, bad16 = 0;
    int first2 = -1, first4 = -1, first16 = -1;
    settle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (en2 !== ((c % 2) == 1))   begin bad2++;  if (first2 < 0)  first2 = c;  end
      if (tx_en !== ((c % 4) == 3)) begin bad4++;  if (first4 < 0)  first4 = c;  end
      if (en16 !== ((c % 16) == 15)) begin bad16++; if (first16 < 0) first16 = c; end
    end
    checks++; if (bad2 != 0)  begin errors++; $display("FAIL div2: got %0d wrong cycles (first %0d) want 0", bad2, first2); end
    checks++; if (bad4 != 0)  begin errors++; $display("FAIL div4: got %0d wrong cycles (first %0d) want 0", bad4, first4); end
    checks++; if (bad16 != 0) begin errors++; $display("FAIL div16: got %0d wrong cycles (first %0d) want 0", bad16, first16); end
    checks++;
    if ({ack2, err2, st2, id2, pi2, ack16, err16, st16, id16, pi16} !== '0) begin
      errors++; $display("FAIL div_idle: got ack2=%b ack16=%b st2=%b st16=%b want idle outputs 0", ack2, ack16, st2, st16);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_all();
    test_fairness();
    test_timeout();
    test_reset_midframe();
    test_divider();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tx_arbiter
